// File: rtl/decode_stage_fwd_pkg.sv
// Shared pipeline package for the MIPS decode stage.
// Holds the word and register-address types, the D and E packets, and the
// opcode and function-code constants.
package decode_stage_fwd_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        creg_addr_t;
  typedef logic [5:0]        opcode_t;
  typedef logic [5:0]        funct_t;

  // Primary opcodes
  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_JAL   = 6'h03;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_ADDIU = 6'h09;
  localparam opcode_t OP_SLTI  = 6'h0A;
  localparam opcode_t OP_SLTIU = 6'h0B;
  localparam opcode_t OP_ANDI  = 6'h0C;
  localparam opcode_t OP_ORI   = 6'h0D;
  localparam opcode_t OP_XORI  = 6'h0E;
  localparam opcode_t OP_LUI   = 6'h0F;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;

  // R-type function codes
  localparam funct_t FN_SLL  = 6'h00;
  localparam funct_t FN_SRL  = 6'h02;
  localparam funct_t FN_JR   = 6'h08;
  localparam funct_t FN_ADDU = 6'h21;
  localparam funct_t FN_SUBU = 6'h23;
  localparam funct_t FN_AND  = 6'h24;
  localparam funct_t FN_OR   = 6'h25;
  localparam funct_t FN_SLT  = 6'h2A;

  localparam creg_addr_t REG_ZERO = 5'd0;
  localparam creg_addr_t REG_RA   = 5'd31;

  // Contents of the F->D pipeline register
  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t instr;
  } D_type;

  // Decoded packet handed to execute
  typedef struct packed {
    opcode_t    OP;
    funct_t     FN;
    word_t      pc;
    creg_addr_t regw;
    logic [4:0] sa;
    word_t      valA;
    word_t      valB;
    word_t      valC;
  } E_type;

  function automatic word_t sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic word_t zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/decode_stage_fwd_fwd_select.sv
// Forwarding priority mux for one source register.
// Scans NFWD producers nearest-first; the first live writer of the register
// supplies the operand, or flags a hazard if its result is still pending.
// Register $0 never matches, so it always reads as zero and never stalls.
module fwd_select #(
  parameter int NFWD   = 2,
  parameter int DATA_W = 32
) (
  input  logic [4:0]           i_reg,
  input  logic [DATA_W-1:0]    i_rf_val,
  input  logic [NFWD-1:0]      i_fwd_valid,
  input  logic [NFWD*5-1:0]    i_fwd_regw,
  input  logic [NFWD*DATA_W-1:0] i_fwd_val,
  input  logic [NFWD-1:0]      i_fwd_pending,
  output logic [DATA_W-1:0]    o_val,
  output logic                 o_hazard
);

  logic [NFWD-1:0] w_match;
  logic            w_found;

  genvar gi;
  generate
    for (gi = 0; gi < NFWD; gi++) begin : g_match
      assign w_match[gi] = i_fwd_valid[gi] &&
                           (i_fwd_regw[gi*5 +: 5] == i_reg) &&
                           (i_reg != 5'd0);
    end
  endgenerate

  // Nearest matching producer wins; no match falls back to the regfile
  always_comb begin
    w_found  = 1'b0;
    o_hazard = 1'b0;
    o_val    = (i_reg == 5'd0) ? '0 : i_rf_val;
    for (int i = 0; i < NFWD; i++) begin
      if (!w_found && w_match[i]) begin
        w_found  = 1'b1;
        o_val    = i_fwd_val[i*DATA_W +: DATA_W];
        o_hazard = i_fwd_pending[i];
      end
    end
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// MIPS decode stage: F->D pipeline register with valid/ready handshake,
// regfile read with nearest-first forwarding, load-use interlock, and
// resolution of J/JAL/JR/BEQ/BNE in D.
// Optional feature macro: DECODE_STALL_CNT_EN adds an interlock cycle counter
// on stall_cnt; without it stall_cnt is tied to zero.
module decode_stage_fwd
  import decode_stage_fwd_pkg::*;
#(
  parameter int NFWD   = 2,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   f_valid,
  input  logic [31:0]            f_pc,
  input  logic [31:0]            f_instr,
  output logic                   d_ready,
  input  logic                   flush,
  output logic [4:0]             rf_ra1,
  output logic [4:0]             rf_ra2,
  input  logic [DATA_W-1:0]      rf_rd1,
  input  logic [DATA_W-1:0]      rf_rd2,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*5-1:0]      fwd_regw,
  input  logic [NFWD*DATA_W-1:0] fwd_val,
  input  logic [NFWD-1:0]        fwd_pending,
  output logic                   e_valid,
  input  logic                   e_ready,
  output E_type                  e_pkt,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic [31:0]            stall_cnt
);

  D_type r_d;

  opcode_t     w_op;
  creg_addr_t  w_rs;
  creg_addr_t  w_rt;
  creg_addr_t  w_rd;
  logic [4:0]  w_sa;
  funct_t      w_fn;
  logic [15:0] w_imm;
  logic [25:0] w_idx;

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_rs_haz;
  logic              w_rt_haz;
  logic              w_use_rs;
  logic              w_use_rt;
  logic              w_hazard;
  logic              w_e_valid;
  logic              w_fire;
  logic              w_taken;
  word_t             w_target;
  E_type             w_pkt;

  assign w_op  = r_d.instr[31:26];
  assign w_rs  = r_d.instr[25:21];
  assign w_rt  = r_d.instr[20:16];
  assign w_rd  = r_d.instr[15:11];
  assign w_sa  = r_d.instr[10:6];
  assign w_fn  = r_d.instr[5:0];
  assign w_imm = r_d.instr[15:0];
  assign w_idx = r_d.instr[25:0];

  assign rf_ra1 = w_rs;
  assign rf_ra2 = w_rt;

  fwd_select #(.NFWD(NFWD), .DATA_W(DATA_W)) u_fwd_rs (
    .i_reg         (w_rs),
    .i_rf_val      (rf_rd1),
    .i_fwd_valid   (fwd_valid),
    .i_fwd_regw    (fwd_regw),
    .i_fwd_val     (fwd_val),
    .i_fwd_pending (fwd_pending),
    .o_val         (w_rs_val),
    .o_hazard      (w_rs_haz)
  );

  fwd_select #(.NFWD(NFWD), .DATA_W(DATA_W)) u_fwd_rt (
    .i_reg         (w_rt),
    .i_rf_val      (rf_rd2),
    .i_fwd_valid   (fwd_valid),
    .i_fwd_regw    (fwd_regw),
    .i_fwd_val     (fwd_val),
    .i_fwd_pending (fwd_pending),
    .o_val         (w_rt_val),
    .o_hazard      (w_rt_haz)
  );

  // Which source registers the held instruction actually reads
  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (w_op)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        w_use_rs = 1'b1;
      end
      default: begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
      end
    endcase
  end

  assign w_hazard  = r_d.valid && ((w_use_rs && w_rs_haz) || (w_use_rt && w_rt_haz));
  assign w_e_valid = r_d.valid && !w_hazard && !flush;
  assign w_fire    = w_e_valid && e_ready;

  // Packet fields and control-transfer resolution from the held instruction
  always_comb begin
    w_pkt      = '0;
    w_pkt.OP   = w_op;
    w_pkt.FN   = w_fn;
    w_pkt.pc   = r_d.pc;
    w_taken    = 1'b0;
    w_target   = '0;
    case (w_op)
      OP_RTYPE: begin
        w_pkt.regw = w_rd;
        w_pkt.valA = word_t'(w_rs_val);
        w_pkt.valB = word_t'(w_rt_val);
        w_pkt.sa   = (w_fn == FN_JR) ? 5'd0 : w_sa;
        if (w_fn == FN_JR) begin
          w_taken  = 1'b1;
          w_target = word_t'(w_rs_val);
        end
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        w_pkt.regw = w_rt;
        w_pkt.valA = word_t'(w_rs_val);
        w_pkt.valB = sext16(w_imm);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_pkt.regw = w_rt;
        w_pkt.valA = word_t'(w_rs_val);
        w_pkt.valB = zext16(w_imm);
      end
      OP_SW: begin
        w_pkt.valA = word_t'(w_rs_val);
        w_pkt.valB = sext16(w_imm);
        w_pkt.valC = word_t'(w_rt_val);
      end
      OP_BEQ, OP_BNE: begin
        w_pkt.valA = word_t'(w_rs_val);
        w_pkt.valB = word_t'(w_rt_val);
        w_target   = r_d.pc + {{14{w_imm[15]}}, w_imm, 2'b00};
        w_taken    = (w_op == OP_BEQ) ? (w_rs_val == w_rt_val)
                                      : (w_rs_val != w_rt_val);
      end
      OP_J: begin
        w_taken  = 1'b1;
        w_target = {r_d.pc[31:28], w_idx, 2'b00};
      end
      OP_JAL: begin
        w_pkt.regw = REG_RA;
        w_pkt.valA = r_d.pc;
        w_pkt.valB = 32'd8;
        w_taken    = 1'b1;
        w_target   = {r_d.pc[31:28], w_idx, 2'b00};
      end
      default: begin
        // Unknown opcode travels as a NOP: no destination, no redirect
        w_pkt.regw = REG_ZERO;
      end
    endcase
  end

  assign e_valid        = w_e_valid;
  assign e_pkt          = w_pkt;
  assign d_ready        = !r_d.valid || w_fire;
  assign redirect_valid = w_fire && w_taken;
  assign redirect_pc    = w_target;

  // D register: flush beats a new fetch, which beats plain drain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
    end else if (flush) begin
      r_d.valid <= 1'b0;
    end else if (f_valid && d_ready) begin
      r_d.valid <= 1'b1;
      r_d.pc    <= f_pc;
      r_d.instr <= f_instr;
    end else if (w_fire) begin
      r_d.valid <= 1'b0;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count every cycle an unflushed instruction sits on an interlock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_d.valid && w_hazard && !flush) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Self-checking bench for decode_stage_fwd: directed scenarios followed by
// randomized traffic, all checked against a behavioural decode model.
module tb_decode_stage_fwd;
  import decode_stage_fwd_pkg::*;

  localparam int NFWD   = 2;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   f_valid;
  logic [31:0]            f_pc;
  logic [31:0]            f_instr;
  logic                   d_ready;
  logic                   flush;
  logic [4:0]             rf_ra1, rf_ra2;
  logic [DATA_W-1:0]      rf_rd1, rf_rd2;
  logic [NFWD-1:0]        fwd_valid;
  logic [NFWD*5-1:0]      fwd_regw;
  logic [NFWD*DATA_W-1:0] fwd_val;
  logic [NFWD-1:0]        fwd_pending;
  logic                   e_valid;
  logic                   e_ready;
  E_type                  e_pkt;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic [31:0]            stall_cnt;

  word_t rf_mem [32];
  assign rf_rd1 = rf_mem[rf_ra1];
  assign rf_rd2 = rf_mem[rf_ra2];

  always #5 clk = ~clk;

  decode_stage_fwd #(.NFWD(NFWD), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .d_ready(d_ready), .flush(flush), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_valid(fwd_valid), .fwd_regw(fwd_regw),
    .fwd_val(fwd_val), .fwd_pending(fwd_pending), .e_valid(e_valid),
    .e_ready(e_ready), .e_pkt(e_pkt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit    m_dv;
  word_t m_pc, m_instr;
  word_t m_cnt;
  bit    x_ev, x_fire, x_dready, x_stall;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_fwd(input int i, input bit v, input int r, input word_t val, input bit p);
    fwd_valid[i]           = v;
    fwd_regw[i*5 +: 5]     = 5'(r);
    fwd_val[i*DATA_W +: DATA_W] = val;
    fwd_pending[i]         = p;
  endtask

  task automatic clr_inputs();
    f_valid = 0; f_pc = 0; f_instr = 0; flush = 0; e_ready = 1;
    fwd_valid = 0; fwd_regw = 0; fwd_val = 0; fwd_pending = 0;
  endtask

  // Nearest live writer of r supplies the value; $0 is hard-wired zero
  task automatic resolve(input logic [4:0] r, output word_t v, output bit haz);
    v = rf_mem[r]; haz = 0;
    if (r == 0) begin v = 0; return; end
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_valid[i] && fwd_regw[i*5 +: 5] == r) begin
        v = fwd_val[i*DATA_W +: DATA_W]; haz = fwd_pending[i];
        return;
      end
    end
  endtask

  // Predict this cycle's outputs from the model, compare, then advance a cycle
  task automatic tick();
    logic [5:0] op; logic [4:0] rs, rt; logic [15:0] imm;
    word_t a, b, tgt; bit ha, hb, ua, ub, taken, redir;
    E_type p;
    #1;
    op = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16]; imm = m_instr[15:0];
    resolve(rs, a, ha); resolve(rt, b, hb);
    ua = op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW};
    ub = op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
    p = '0; p.OP = op; p.FN = m_instr[5:0]; p.pc = m_pc; taken = 0; tgt = 0;
    if (op == OP_RTYPE) begin
      p.regw = m_instr[15:11]; p.valA = a; p.valB = b;
      p.sa = (m_instr[5:0] == FN_JR) ? 5'd0 : m_instr[10:6];
      if (m_instr[5:0] == FN_JR) begin taken = 1; tgt = a; end
    end else if (op inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW}) begin
      p.regw = rt; p.valA = a; p.valB = word_t'(int'($signed(imm)));
    end else if (op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) begin
      p.regw = rt; p.valA = a; p.valB = word_t'(int'(imm));
    end else if (op == OP_SW) begin
      p.valA = a; p.valB = word_t'(int'($signed(imm))); p.valC = b;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      p.valA = a; p.valB = b;
      tgt = m_pc + word_t'(int'($signed(imm)) * 4);
      taken = (op == OP_BEQ) ? (a == b) : (a != b);
    end else if (op == OP_J || op == OP_JAL) begin
      taken = 1; tgt = {m_pc[31:28], m_instr[25:0], 2'b00};
      if (op == OP_JAL) begin p.regw = 31; p.valA = m_pc; p.valB = 8; end
    end
    x_stall  = m_dv && ((ua && ha) || (ub && hb)) && !flush;
    x_ev     = m_dv && !((ua && ha) || (ub && hb)) && !flush;
    x_fire   = x_ev && e_ready;
    x_dready = !m_dv || x_fire;
    redir    = x_fire && taken;
    check("e_valid", e_valid, x_ev);
    check("d_ready", d_ready, x_dready);
    check("redirect_valid", redirect_valid, redir);
    if (x_ev) check("e_pkt", e_pkt, p);
    if (redir) check("redirect_pc", redirect_pc, tgt);
    check("stall_cnt", stall_cnt, m_cnt);
    if (x_fire)
      $display("fire pc=%08h instr=%08h regw=%0d valA=%08h valB=%08h redirect=%0b",
               m_pc, m_instr, p.regw, p.valA, p.valB, redir);
    @(posedge clk);
    if (reset) begin
      m_dv = 0; m_pc = 0; m_instr = 0; m_cnt = 0;
    end else begin
`ifdef DECODE_STALL_CNT_EN
      if (x_stall) m_cnt = m_cnt + 1;
`endif
      if (flush) m_dv = 0;
      else if (f_valid && x_dready) begin m_dv = 1; m_pc = f_pc; m_instr = f_instr; end
      else if (x_fire) m_dv = 0;
    end
    @(negedge clk);
  endtask

  function automatic word_t rand_instr();
    logic [5:0] ops [16];
    logic [5:0] op;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h00};
    op = ops[$urandom_range(0, 15)];
    if (op == OP_RTYPE)
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
              5'($urandom), ($urandom_range(0, 3) == 0) ? FN_JR : FN_ADDU};
    if (op == OP_J || op == OP_JAL)
      return {op, 26'($urandom)};
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'h0 : $urandom;
    clr_inputs();
    reset = 1;
    m_dv = 0; m_pc = 0; m_instr = 0; m_cnt = 0;
    @(posedge clk); @(negedge clk);
    #1;
    check("reset e_pkt", e_pkt, E_type'(0));
    check("reset d_ready", d_ready, 1'b1);
    tick();
    reset = 0;

    // Load-use interlock on BEQ $4,$4 then release
    f_valid = 1; f_pc = 32'h100; f_instr = {OP_BEQ, 5'd4, 5'd4, 16'd3};
    tick();
    f_valid = 0; set_fwd(0, 1, 4, 32'h0, 1);
    #1 check("loaduse stall e_valid", e_valid, 1'b0);
    tick();
    set_fwd(0, 1, 4, 32'h55, 0);
    #1 check("loaduse redirect_valid", redirect_valid, 1'b1);
    check("loaduse redirect_pc", redirect_pc, 32'h10C);
`ifdef DECODE_STALL_CNT_EN
    check("loaduse stall_cnt", stall_cnt, 32'd1);
`else
    check("loaduse stall_cnt", stall_cnt, 32'd0);
`endif
    tick();
    clr_inputs();

    // Forward priority: nearest producer wins
    f_valid = 1; f_pc = 32'h40; f_instr = {OP_RTYPE, 5'd5, 5'd0, 5'd3, 5'd0, FN_ADDU};
    tick();
    f_valid = 0; set_fwd(0, 1, 5, 32'h11, 0); set_fwd(1, 1, 5, 32'h22, 0);
    #1 check("prio valA", e_pkt.valA, 32'h11);
    check("prio e_valid", e_valid, 1'b1);
    tick();
    clr_inputs();

    // $0 never matches a producer
    f_valid = 1; f_pc = 32'h80; f_instr = {OP_ORI, 5'd0, 5'd2, 16'h0001};
    tick();
    f_valid = 0; set_fwd(0, 1, 0, 32'hDEAD, 1);
    #1 check("zero e_valid", e_valid, 1'b1);
    check("zero valA", e_pkt.valA, 32'h0);
    check("zero valB", e_pkt.valB, 32'h1);
    tick();
    clr_inputs();

    // JAL target and link fields
    f_valid = 1; f_pc = 32'h80001000; f_instr = 32'h0C000040;
    tick();
    f_valid = 0;
    #1 check("jal redirect_pc", redirect_pc, 32'h80000100);
    check("jal regw", e_pkt.regw, 5'd31);
    check("jal valA", e_pkt.valA, 32'h80001000);
    check("jal valB", e_pkt.valB, 32'd8);
    tick();

    // Backpressure holds D; flush empties it without taking fetch
    f_valid = 1; f_pc = 32'h200; f_instr = {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADDU};
    tick();
    e_ready = 0; f_pc = 32'h204; f_instr = {OP_ORI, 5'd1, 5'd2, 16'h7};
    #1 check("bp d_ready", d_ready, 1'b0);
    tick();
    #1 check("bp hold pc", e_pkt.pc, 32'h200);
    tick();
    flush = 1;
    tick();
    flush = 0; f_valid = 0; e_ready = 1;
    #1 check("flush empty e_valid", e_valid, 1'b0);
    check("flush d_ready", d_ready, 1'b1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      f_valid = ($urandom_range(0, 9) < 7);
      f_pc    = {$urandom} & 32'hFFFF_FFFC;
      f_instr = rand_instr();
      flush   = ($urandom_range(0, 9) == 0);
      e_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NFWD; i++)
        set_fwd(i, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                $urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
